// File: rtl/bus_round_robin_arbiter.sv
// Round-robin arbiter for one shared memory bus.
// Registered one-hot grant, hold timeout with per-core lockout until RQ drops.
module bus_round_robin_arbiter #(
    parameter int N_MASTERS = 4,
    parameter int MAX_HOLD  = 16,
    parameter int OWNER_W   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_MASTERS-1:0] Bus_RQ,
    input  logic                 Bus_Mem_Ready,
    output logic [N_MASTERS-1:0] Bus_GRANT,
    output logic                 Bus_Busy,
    output logic [OWNER_W-1:0]   Grant_Owner,
    output logic                 Timeout_Err
);

    localparam int HW = $clog2(MAX_HOLD + 2);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        WAIT_MEM_LOW
    } state_t;

    state_t state, stateNext;

    logic [OWNER_W-1:0]   rrPtr, rrPtrNext;
    logic [OWNER_W-1:0]   ownerNext, winner, cand;
    logic [HW-1:0]        holdCnt, holdCntNext;
    logic [N_MASTERS-1:0] mask, maskNext;
    logic [N_MASTERS-1:0] grantNext, eligible;
    logic                 busyNext, timeoutNext;
    logic                 found, holdLimit;

    assign eligible  = Bus_RQ & ~mask;
    assign holdLimit = (MAX_HOLD != 0) && (holdCnt == HW'(MAX_HOLD));

    // Search starts just after the last winner, wrapping modulo N_MASTERS
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int off = 1; off <= N_MASTERS; off++) begin
            cand = OWNER_W'((int'(rrPtr) + off) % N_MASTERS);
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        stateNext   = state;
        rrPtrNext   = rrPtr;
        ownerNext   = Grant_Owner;
        holdCntNext = holdCnt;
        grantNext   = Bus_GRANT;
        busyNext    = Bus_Busy;
        timeoutNext = 1'b0;
        maskNext    = mask & Bus_RQ;
        unique case (state)
            IDLE: begin
                if (found && !Bus_Mem_Ready) begin
                    stateNext   = GRANT;
                    rrPtrNext   = winner;
                    ownerNext   = winner;
                    holdCntNext = HW'(1);
                    grantNext   = N_MASTERS'(1) << winner;
                    busyNext    = 1'b1;
                end
            end
            GRANT: begin
                if (!Bus_RQ[Grant_Owner]) begin
                    stateNext = WAIT_MEM_LOW;
                    grantNext = '0;
                    busyNext  = 1'b0;
                end else if (holdLimit) begin
                    // Revoked owner stays locked out until it drops RQ
                    stateNext             = WAIT_MEM_LOW;
                    grantNext             = '0;
                    busyNext              = 1'b0;
                    timeoutNext           = 1'b1;
                    maskNext[Grant_Owner] = 1'b1;
                end else if (holdCnt != '1) begin
                    holdCntNext = holdCnt + 1'b1;
                end
            end
            WAIT_MEM_LOW: begin
                if (!Bus_Mem_Ready) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            rrPtr       <= OWNER_W'(N_MASTERS - 1);
            holdCnt     <= '0;
            mask        <= '0;
            Bus_GRANT   <= '0;
            Bus_Busy    <= 1'b0;
            Grant_Owner <= '0;
            Timeout_Err <= 1'b0;
        end else begin
            state       <= stateNext;
            rrPtr       <= rrPtrNext;
            holdCnt     <= holdCntNext;
            mask        <= maskNext;
            Bus_GRANT   <= grantNext;
            Bus_Busy    <= busyNext;
            Grant_Owner <= ownerNext;
            Timeout_Err <= timeoutNext;
        end
    end

endmodule

// File: tb/tb_bus_round_robin_arbiter.sv
// Bench for bus_round_robin_arbiter: vector table, directed corner
// sequences and random traffic against a behavioural model.
module tb_bus_round_robin_arbiter;

    localparam int N    = 4;
    localparam int MAXH = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] Bus_RQ = '0;
    logic         Bus_Mem_Ready = 1'b0;
    logic [N-1:0] Bus_GRANT;
    logic         Bus_Busy;
    logic [1:0]   Grant_Owner;
    logic         Timeout_Err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bus_round_robin_arbiter #(
        .N_MASTERS(N),
        .MAX_HOLD (MAXH),
        .OWNER_W  (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .Bus_RQ       (Bus_RQ),
        .Bus_Mem_Ready(Bus_Mem_Ready),
        .Bus_GRANT    (Bus_GRANT),
        .Bus_Busy     (Bus_Busy),
        .Grant_Owner  (Grant_Owner),
        .Timeout_Err  (Timeout_Err)
    );

    // Model: who owns the bus, how long, whether a turnaround is pending
    int       mOwner;
    int       mHeld;
    int       mPtr;
    int       mShown;
    bit       mTurn;
    bit       mTo;
    bit [N-1:0] mBlk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic bit bitAt(input bit [N-1:0] v, input int i);
        logic [1:0] ix;
        ix = 2'(i);
        return v[ix];
    endfunction

    function automatic logic [31:0] expGrant();
        return (mOwner >= 0) ? (32'd1 << mOwner) : 32'd0;
    endfunction

    task automatic modelReset();
        mOwner = -1;
        mHeld  = 0;
        mPtr   = N - 1;
        mShown = 0;
        mTurn  = 1'b0;
        mTo    = 1'b0;
        mBlk   = '0;
    endtask

    task automatic modelStep(input bit [N-1:0] rq, input bit mr);
        bit [N-1:0] nb;
        nb  = mBlk & rq;
        mTo = 1'b0;
        if (mOwner >= 0) begin
            if (!bitAt(rq, mOwner)) begin
                mOwner = -1;
                mTurn  = 1'b1;
            end else if (mHeld == MAXH) begin
                nb     = nb | (N'(1) << mOwner);
                mOwner = -1;
                mTurn  = 1'b1;
                mTo    = 1'b1;
            end else begin
                mHeld++;
            end
        end else if (mTurn) begin
            if (!mr) mTurn = 1'b0;
        end else if (!mr) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (mPtr + k) % N;
                if (bitAt(rq, c) && !bitAt(mBlk, c)) begin
                    mOwner = c;
                    mPtr   = c;
                    mShown = c;
                    mHeld  = 1;
                    break;
                end
            end
        end
        mBlk = nb;
    endtask

    task automatic cycle(input logic [N-1:0] rq, input logic mr);
        Bus_RQ        = rq;
        Bus_Mem_Ready = mr;
        @(posedge clk);
        modelStep(rq, mr);
        #1;
        chk("grant", Bus_GRANT, expGrant());
        chk("busy", Bus_Busy, (mOwner >= 0));
        chk("owner", Grant_Owner, mShown);
        chk("timeout", Timeout_Err, mTo);
        chk("onehot", $onehot0(Bus_GRANT), 1);
    endtask

    task automatic resetDut();
        Bus_RQ        = '0;
        Bus_Mem_Ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        #1;
        chk("rst_grant", Bus_GRANT, 0);
        chk("rst_busy", Bus_Busy, 0);
        chk("rst_owner", Grant_Owner, 0);
        chk("rst_timeout", Timeout_Err, 0);
        #100;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        modelStep('0, 1'b0);
        #1;
    endtask

    typedef struct {
        logic [N-1:0] rq;
        logic         mr;
        logic [N-1:0] g;
        logic         busy;
        logic [1:0]   own;
        logic         to;
    } vec_t;

    vec_t tbl[16];

    int held, pulses, regrant, starts;
    bit got;
    logic [N-1:0] rq, prevG;
    int age;
    int order[$];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        // single request, release, mem-busy hold-off, turnaround
        tbl[0]  = '{4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0};
        tbl[1]  = '{4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0};
        tbl[2]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[3]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[4]  = '{4'b0010, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[5]  = '{4'b0010, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[6]  = '{4'b0010, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[7]  = '{4'b0010, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[8]  = '{4'b0010, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[9]  = '{4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0};
        tbl[10] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0};
        tbl[11] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b0};
        tbl[12] = '{4'b0100, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b0};
        tbl[13] = '{4'b0100, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0};
        tbl[14] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0};
        tbl[15] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0};

        #2;
        resetDut();
        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].rq, tbl[i].mr);
            chk($sformatf("vec%0d_grant", i), Bus_GRANT, tbl[i].g);
            chk($sformatf("vec%0d_busy", i), Bus_Busy, tbl[i].busy);
            chk($sformatf("vec%0d_owner", i), Grant_Owner, tbl[i].own);
            chk($sformatf("vec%0d_timeout", i), Timeout_Err, tbl[i].to);
        end

        // round robin: all request, each owner drops 3 cycles after grant
        resetDut();
        rq     = 4'b1111;
        prevG  = '0;
        age    = 0;
        starts = 0;
        for (int i = 0; i < 200 && starts < 5; i++) begin
            cycle(rq, 1'b0);
            if (Bus_GRANT != 0 && Bus_GRANT != prevG) begin
                order.push_back(int'(Grant_Owner));
                starts++;
                age = 1;
            end else if (Bus_GRANT != 0) begin
                age++;
            end
            prevG = Bus_GRANT;
            rq = (Bus_GRANT != 0 && age == 3) ? (4'b1111 & ~Bus_GRANT) : 4'b1111;
        end
        chk("rr_count", order.size(), 5);
        for (int i = 0; i < order.size() && i < 5; i++)
            chk($sformatf("rr_order%0d", i), order[i], i % 4);

        // timeout on core 2, core 3 next, core 2 locked out until RQ drops
        resetDut();
        cycle(4'b0100, 1'b0);
        chk("to_first", Bus_GRANT, 4'b0100);
        held   = 1;
        pulses = 0;
        got    = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            cycle(4'b1100, 1'b0);
            if (Bus_GRANT == 4'b0100) held++;
            if (Timeout_Err) pulses++;
            if (Bus_GRANT == 4'b1000) got = 1'b1;
        end
        chk("to_hold_cycles", held, MAXH);
        chk("to_pulses", pulses, 1);
        chk("to_core3_next", got, 1);
        cycle(4'b0100, 1'b0);
        regrant = 0;
        repeat (6) begin
            cycle(4'b0100, 1'b0);
            if (Bus_GRANT[2]) regrant++;
        end
        chk("to_masked", regrant, 0);
        cycle(4'b0000, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            cycle(4'b0100, 1'b0);
            if (Bus_GRANT == 4'b0100) got = 1'b1;
        end
        chk("to_unmasked_regrant", got, 1);

        // asynchronous reset while core 3 owns the bus
        resetDut();
        cycle(4'b1000, 1'b0);
        chk("rst_pre_grant", Bus_GRANT, 4'b1000);
        cycle(4'b1000, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_mid_grant", Bus_GRANT, 0);
        chk("rst_mid_busy", Bus_Busy, 0);
        chk("rst_mid_timeout", Timeout_Err, 0);
        modelReset();
        @(negedge clk);
        reset = 1'b1;
        cycle(4'b1000, 1'b0);
        chk("rst_regrant", Bus_GRANT, 4'b1000);

        // pointer wrap from core 3 to core 0, then core 2
        resetDut();
        cycle(4'b0101, 1'b0);
        chk("wrap_core0", Bus_GRANT, 4'b0001);
        cycle(4'b0100, 1'b0);
        cycle(4'b0100, 1'b0);
        cycle(4'b0100, 1'b0);
        chk("wrap_core2", Bus_GRANT, 4'b0100);

        // random traffic against the model
        resetDut();
        rq = '0;
        repeat (3000) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
            cycle(rq, ($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
